wb_scoreboard: RTL and testbench

Writeback-side companion to the 32-entry register file in the non-forwarding pipeline. Registers retiring results into a one-entry commit stage and drives the register file write port. Keeps a per-register count of in-flight writes issued by decode. Produces a decode stall whenever a source operand, or an over-subscribed destination, still has a write outstanding, so operands are read only after their producer's write has landed.

---
 rtl/wb_scoreboard.sv | 159 +++++++++++++++
 tb/tb_wb_scoreboard.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// wb_scoreboard
//
// Writeback-side companion to the 32-entry register file of the
// non-forwarding pipeline. It does three things:
//   * holds retiring results in a one-entry commit register that drives
//     the register file write port,
//   * keeps a per-register count of writes that decode has issued but
//     that have not yet landed in the register file,
//   * stalls decode while a source operand still has a write in flight,
//     or while the destination already has MAX_PEND writes in flight.
//
// Ports
//   clk_i, rst_i         clock and synchronous active-high reset
//   id_valid_i           decode holds a valid instruction
//   id_rs1/rs2_addr_i    source register addresses
//   id_rs1/rs2_used_i    instruction actually reads rs1 / rs2
//   id_rd_wren_i         instruction writes rd
//   id_rd_addr_i         destination address
//   id_stall_o           combinational hold request to decode
//   wb_valid_i           writeback retires an instruction this cycle
//   wb_rd_wren_i         retiring instruction writes rd
//   wb_rd_addr_i         retiring destination
//   wb_rd_data_i         retiring result
//   rd_wren_o            register file write enable (registered)
//   rd_addr_o            register file write address (registered)
//   rd_data_o            register file write data (registered)
//   busy_o               some register still has a write in flight
//   err_o                sticky: a commit hit a register with nothing pending

module wb_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_PEND   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  id_valid_i,
    input  logic [4:0]            id_rs1_addr_i,
    input  logic [4:0]            id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  id_rd_wren_i,
    input  logic [4:0]            id_rd_addr_i,
    output logic                  id_stall_o,

    input  logic                  wb_valid_i,
    input  logic                  wb_rd_wren_i,
    input  logic [4:0]            wb_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_rd_data_i,

    output logic                  rd_wren_o,
    output logic [4:0]            rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,

    output logic                  busy_o,
    output logic                  err_o
);

    localparam int               CNT_W     = $clog2(MAX_PEND + 1);
    localparam logic [CNT_W-1:0] PEND_FULL = CNT_W'(MAX_PEND);

    logic [CNT_W-1:0]    pend [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                src1_hz;
    logic                src2_hz;
    logic                dst_full;
    logic                issue_fire;
    logic                dec_empty;

    // Hazard detection looks only at the registered counters, never at the
    // writeback inputs of the same cycle: an operand becomes readable only
    // once its commit register write has actually happened. An instruction
    // whose source equals its own destination sees only older writes here,
    // because its own increment has not happened yet.
    always_comb begin
        src1_hz    = id_rs1_used_i && (id_rs1_addr_i != 5'd0) && (pend[id_rs1_addr_i] != '0);
        src2_hz    = id_rs2_used_i && (id_rs2_addr_i != 5'd0) && (pend[id_rs2_addr_i] != '0);
        dst_full   = id_rd_wren_i  && (id_rd_addr_i  != 5'd0) && (pend[id_rd_addr_i]  == PEND_FULL);
        id_stall_o = id_valid_i && (src1_hz || src2_hz || dst_full);
        issue_fire = id_valid_i && !id_stall_o;
    end

    // One-hot increment/decrement requests. The decrement is tied to the
    // cycle the register file write is presented, so the stall drops on
    // exactly the cycle the data becomes readable. x0 can never be
    // selected: issue filters rd==0 and rd_wren_o is never set for x0.
    // A commit to a register with nothing pending does not decrement.
    always_comb begin
        inc_vec   = '0;
        dec_vec   = '0;
        dec_empty = 1'b0;
        if (issue_fire && id_rd_wren_i && (id_rd_addr_i != 5'd0)) begin
            inc_vec[id_rd_addr_i] = 1'b1;
        end
        if (rd_wren_o) begin
            if (pend[rd_addr_o] != '0) begin
                dec_vec[rd_addr_o] = 1'b1;
            end else begin
                dec_empty = 1'b1;
            end
        end
    end

    // Pending counters. Issue and commit on the same register cancel out.
    // Saturation cannot overflow because dst_full blocks the issue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    pend[r] <= pend[r] + CNT_W'(1);
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    pend[r] <= pend[r] - CNT_W'(1);
                end
            end
        end
    end

    // Commit register. Writeback has no backpressure: every retire is
    // captured. Address and data hold between retires so the write port
    // does not toggle needlessly; the enable alone qualifies the write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_wren_o <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            rd_wren_o <= wb_valid_i && wb_rd_wren_i && (wb_rd_addr_i != 5'd0);
            if (wb_valid_i) begin
                rd_addr_o <= wb_rd_addr_i;
                rd_data_o <= wb_rd_data_i;
            end
        end
    end

    // Sticky error: a commit arrived for a register decode never issued a
    // write to. The register file write itself still goes ahead.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (dec_empty) begin
            err_o <= 1'b1;
        end
    end

    // Busy when any counter is non-zero; purely from registered state.
    always_comb begin
        busy_o = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_o = busy_o | (pend[r] != '0);
        end
    end

endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard
//
// Bench for wb_scoreboard. Each cycle is described by one vector record
// holding the decode and writeback inputs plus the expected stall (seen
// before the clock edge) and the expected busy/err (seen after it). The
// commit register contents are predicted when the vector is driven and
// queued; they are popped and compared after the clock edge.

module tb_wb_scoreboard;

    logic        clk_i;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic        id_rd_wren_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_stall_o;
    logic        wb_valid_i;
    logic        wb_rd_wren_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_data_i;
    logic        rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        busy_o;
    logic        err_o;

    wb_scoreboard #(
        .NUM_REGS   (32),
        .DATA_WIDTH (32),
        .MAX_PEND   (3)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rd_wren_i  (id_rd_wren_i),
        .id_rd_addr_i  (id_rd_addr_i),
        .id_stall_o    (id_stall_o),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_wren_i  (wb_rd_wren_i),
        .wb_rd_addr_i  (wb_rd_addr_i),
        .wb_rd_data_i  (wb_rd_data_i),
        .rd_wren_o     (rd_wren_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_o     (rd_data_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        id_valid;
        logic        rs1_used;
        logic [4:0]  rs1;
        logic        rs2_used;
        logic [4:0]  rs2;
        logic        rd_wren;
        logic [4:0]  rd;
        logic        wb_valid;
        logic        wb_wren;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        exp_stall;
        logic        exp_busy;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        wren;
        logic [4:0]  addr;
        logic [31:0] data;
    } commit_t;

    commit_t     exp_q[$];
    vec_t        tbl[$];
    logic [4:0]  held_addr;
    logic [31:0] held_data;
    int          checks;
    int          errors;

    // Free-running clock, 10 ns period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard stop in case something wedges the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t vec(input string name, input int rst, input int id_valid,
                                 input int rs1_used, input int rs1, input int rs2_used, input int rs2,
                                 input int rd_wren, input int rd, input int wb_valid, input int wb_wren,
                                 input int wb_addr, input int wb_data,
                                 input int exp_stall, input int exp_busy, input int exp_err);
        vec_t v;
        v.name      = name;
        v.rst       = 1'(rst);
        v.id_valid  = 1'(id_valid);
        v.rs1_used  = 1'(rs1_used);
        v.rs1       = 5'(rs1);
        v.rs2_used  = 1'(rs2_used);
        v.rs2       = 5'(rs2);
        v.rd_wren   = 1'(rd_wren);
        v.rd        = 5'(rd);
        v.wb_valid  = 1'(wb_valid);
        v.wb_wren   = 1'(wb_wren);
        v.wb_addr   = 5'(wb_addr);
        v.wb_data   = 32'(wb_data);
        v.exp_stall = 1'(exp_stall);
        v.exp_busy  = 1'(exp_busy);
        v.exp_err   = 1'(exp_err);
        return v;
    endfunction

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", what, act, exp);
        end
    endtask

    // Drive one cycle of inputs and predict what the commit register will
    // hold after the coming clock edge.
    task automatic applyStimulus(input vec_t v);
        commit_t c;
        rst_i         = v.rst;
        id_valid_i    = v.id_valid;
        id_rs1_used_i = v.rs1_used;
        id_rs1_addr_i = v.rs1;
        id_rs2_used_i = v.rs2_used;
        id_rs2_addr_i = v.rs2;
        id_rd_wren_i  = v.rd_wren;
        id_rd_addr_i  = v.rd;
        wb_valid_i    = v.wb_valid;
        wb_rd_wren_i  = v.wb_wren;
        wb_rd_addr_i  = v.wb_addr;
        wb_rd_data_i  = v.wb_data;
        if (v.rst) begin
            held_addr = 5'd0;
            held_data = 32'd0;
        end else if (v.wb_valid) begin
            held_addr = v.wb_addr;
            held_data = v.wb_data;
        end
        c.wren = !v.rst && v.wb_valid && v.wb_wren && (v.wb_addr != 5'd0);
        c.addr = held_addr;
        c.data = held_data;
        exp_q.push_back(c);
    endtask

    // Compare registered outputs after the clock edge.
    task automatic checkOutput(input vec_t v);
        commit_t c;
        if (exp_q.size() == 0) begin
            check({v.name, " queue"}, 32'd0, 32'd1);
        end else begin
            c = exp_q.pop_front();
            check({v.name, " rd_wren"}, 32'(rd_wren_o), 32'(c.wren));
            check({v.name, " rd_addr"}, 32'(rd_addr_o), 32'(c.addr));
            check({v.name, " rd_data"}, rd_data_o, c.data);
        end
        check({v.name, " busy"}, 32'(busy_o), 32'(v.exp_busy));
        check({v.name, " err"},  32'(err_o),  32'(v.exp_err));
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(v);
        #1;
        check({v.name, " stall"}, 32'(id_stall_o), 32'(v.exp_stall));
        @(posedge clk_i);
        #1;
        checkOutput(v);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        held_addr = 5'd0;
        held_data = 32'd0;
        applyStimulus(vec("init", 1, 0,0,0,0,0,0,0, 0,0,0,0, 0,0,0));
        void'(exp_q.pop_front());
        @(posedge clk_i);
        #1;

        //              name           rst val u1 rs1 u2 rs2 wr rd  wbv wbw wba wbd           stl bsy err
        tbl.push_back(vec("reset_a",     1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,            0,  0,  0));
        tbl.push_back(vec("reset_b",     1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,            0,  0,  0));
        tbl.push_back(vec("rs1_x5_free", 0, 1, 1, 5, 0, 0, 0, 0,  0, 0, 0, 0,            0,  0,  0));
        tbl.push_back(vec("issue_x5",    0, 1, 0, 0, 0, 0, 1, 5,  0, 0, 0, 0,            0,  1,  0));
        tbl.push_back(vec("raw_wb",      0, 1, 1, 5, 0, 0, 0, 0,  1, 1, 5, 32'hDEADBEEF, 1,  1,  0));
        tbl.push_back(vec("raw_n1",      0, 1, 1, 5, 0, 0, 0, 0,  0, 0, 0, 0,            1,  0,  0));
        tbl.push_back(vec("raw_n2",      0, 1, 1, 5, 0, 0, 0, 0,  0, 0, 0, 0,            0,  0,  0));
        tbl.push_back(vec("x0_issue",    0, 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0,            0,  0,  0));
        tbl.push_back(vec("x0_read_wb",  0, 1, 1, 0, 1, 0, 1, 0,  1, 1, 0, 32'h00001234, 0,  0,  0));
        tbl.push_back(vec("x0_after",    0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,            0,  0,  0));
        tbl.push_back(vec("self_prior",  0, 1, 0, 0, 0, 0, 1, 5,  0, 0, 0, 0,            0,  1,  0));
        tbl.push_back(vec("self_stall",  0, 1, 1, 5, 0, 0, 1, 5,  0, 0, 0, 0,            1,  1,  0));
        tbl.push_back(vec("self_wb",     0, 1, 1, 5, 0, 0, 1, 5,  1, 1, 5, 32'hA5A5A5A5, 1,  1,  0));
        tbl.push_back(vec("self_n1",     0, 1, 1, 5, 0, 0, 1, 5,  0, 0, 0, 0,            1,  0,  0));
        tbl.push_back(vec("self_fire",   0, 1, 1, 5, 0, 0, 1, 5,  0, 0, 0, 0,            0,  1,  0));
        tbl.push_back(vec("novalid",     0, 0, 1, 5, 1, 5, 0, 0,  0, 0, 0, 0,            0,  1,  0));
        tbl.push_back(vec("rs2_hz_wb",   0, 1, 0, 0, 1, 5, 0, 0,  1, 1, 5, 32'h00000055, 1,  1,  0));
        tbl.push_back(vec("rs2_drain",   0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,            0,  0,  0));
        tbl.push_back(vec("idle",        0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,            0,  0,  0));

        for (int i = 0; i < tbl.size(); i++) begin
            runVector(tbl[i]);
        end

        // Saturation on x7: three issues fill it, the fourth stalls until
        // one commit lands, then fires two cycles after the writeback.
        runVector(vec("sat_1",      0, 1, 0, 0, 0, 0, 1, 7,  0, 0, 0, 0,            0, 1, 0));
        runVector(vec("sat_2",      0, 1, 0, 0, 0, 0, 1, 7,  0, 0, 0, 0,            0, 1, 0));
        runVector(vec("sat_3",      0, 1, 0, 0, 0, 0, 1, 7,  0, 0, 0, 0,            0, 1, 0));
        runVector(vec("sat_4_wb",   0, 1, 0, 0, 0, 0, 1, 7,  1, 1, 7, 32'h00000077, 1, 1, 0));
        runVector(vec("sat_4_n1",   0, 1, 0, 0, 0, 0, 1, 7,  0, 0, 0, 0,            1, 1, 0));
        runVector(vec("sat_4_fire", 0, 1, 0, 0, 0, 0, 1, 7,  0, 0, 0, 0,            0, 1, 0));
        runVector(vec("sat_full",   0, 1, 0, 0, 0, 0, 1, 7,  0, 0, 0, 0,            1, 1, 0));
        runVector(vec("sat_dr_1",   0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 7, 32'h00000070, 0, 1, 0));
        runVector(vec("sat_dr_2",   0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 7, 32'h00000071, 0, 1, 0));
        runVector(vec("sat_dr_3",   0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 7, 32'h00000072, 0, 1, 0));
        runVector(vec("sat_empty",  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,            0, 0, 0));

        // Issue to x9 in the same cycle its commit lands: count stays 1,
        // proven by exactly one more commit clearing it.
        runVector(vec("sim_issue",  0, 1, 0, 0, 0, 0, 1, 9,  0, 0, 0, 0,            0, 1, 0));
        runVector(vec("sim_wb",     0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 9, 32'h00000099, 0, 1, 0));
        runVector(vec("sim_both",   0, 1, 0, 0, 0, 0, 1, 9,  0, 0, 0, 0,            0, 1, 0));
        runVector(vec("sim_hz_wb",  0, 1, 1, 9, 0, 0, 0, 0,  1, 1, 9, 32'h0000009A, 1, 1, 0));
        runVector(vec("sim_n1",     0, 1, 1, 9, 0, 0, 0, 0,  0, 0, 0, 0,            1, 0, 0));
        runVector(vec("sim_free",   0, 1, 1, 9, 0, 0, 0, 0,  0, 0, 0, 0,            0, 0, 0));

        // Commit to x12 with nothing pending: write still goes out, error
        // rises two cycles after the writeback and stays up.
        runVector(vec("spur_wb",    0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 12, 32'hC0FFEE00, 0, 0, 0));
        runVector(vec("spur_n1",    0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,            0, 0, 1));
        runVector(vec("spur_n2",    0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,            0, 0, 1));
        runVector(vec("spur_n3",    0, 1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 1));

        // Reset in the middle of traffic: counters, error and the pending
        // commit are all dropped; the next instruction issues freely.
        runVector(vec("mid_issue",  0, 1, 0, 0, 0, 0, 1, 3,  0, 0, 0, 0,            0, 1, 1));
        runVector(vec("mid_rst",    1, 1, 1, 3, 0, 0, 0, 0,  1, 1, 3, 32'h00000033, 1, 0, 0));
        runVector(vec("mid_after",  0, 1, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0,            0, 0, 0));
        runVector(vec("mid_idle",   0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,            0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
